// File: rtl/sync_ram_arbiter.sv
// Round-robin arbiter and sequencer that serialises two valid/ready requesters onto one
// single-port synchronous RAM and routes read data back to the port that issued the read.
module sync_ram_arbiter #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 4,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic              ram_we,
  output logic              ram_re,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              busy
);

  typedef enum logic [1:0] {StIdle, StIssue, StRdWait, StResp} state_e;

  localparam logic [2:0] LastCnt = 3'(RD_LAT - 1);

  state_e     state_q, state_d;
  logic       last_b_q;  // 1 when B holds the most recent grant, so A wins the next tie
  logic       gnt_b_q;
  logic       we_q;
  logic [2:0] cnt_q;
  logic       pick_a, pick_b;

  always_comb begin
    pick_a = a_valid && (!b_valid || last_b_q);
    pick_b = b_valid && !pick_a;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (pick_a || pick_b) state_d = StIssue;
      StIssue:  state_d = we_q ? StIdle : StRdWait;
      StRdWait: if (cnt_q == LastCnt) state_d = StResp;
      StResp:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    a_ready  = !rst && (state_q == StIdle) && pick_a;
    b_ready  = !rst && (state_q == StIdle) && pick_b;
    busy     = (state_q != StIdle);
    a_rvalid = (state_q == StResp) && !gnt_b_q;
    b_rvalid = (state_q == StResp) && gnt_b_q;
  end

  // Request latch, RAM strobes (high only during the issue cycle) and read return path
  always_ff @(posedge clk) begin
    if (rst) begin
      last_b_q <= 1'b1;
      gnt_b_q  <= 1'b0;
      we_q     <= 1'b0;
      cnt_q    <= '0;
      ram_we   <= 1'b0;
      ram_re   <= 1'b0;
      ram_addr <= '0;
      ram_din  <= '0;
      a_rdata  <= '0;
      b_rdata  <= '0;
    end else begin
      ram_we <= 1'b0;
      ram_re <= 1'b0;
      if (a_ready) begin
        gnt_b_q  <= 1'b0;
        last_b_q <= 1'b0;
        we_q     <= a_we;
        ram_we   <= a_we;
        ram_re   <= !a_we;
        ram_addr <= a_addr;
        ram_din  <= a_wdata;
      end else if (b_ready) begin
        gnt_b_q  <= 1'b1;
        last_b_q <= 1'b1;
        we_q     <= b_we;
        ram_we   <= b_we;
        ram_re   <= !b_we;
        ram_addr <= b_addr;
        ram_din  <= b_wdata;
      end

      if (state_q == StIssue) begin
        cnt_q <= '0;
      end else if (state_q == StRdWait) begin
        cnt_q <= cnt_q + 3'd1;
      end

      if (state_q == StRdWait && cnt_q == LastCnt) begin
        if (gnt_b_q) begin
          b_rdata <= ram_dout;
        end else begin
          a_rdata <= ram_dout;
        end
      end
    end
  end

endmodule

// File: tb/tb_sync_ram_arbiter.sv
// Directed bench: two arbiter instances (read latency 1 and 3) each in front of a behavioural
// synchronous RAM, driven by a linear sequence of steps with hand-computed expectations.
module tb_sync_ram_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Instance 1: RD_LAT = 1
  logic       a_valid, a_ready, a_we, a_rvalid;
  logic [3:0] a_addr, a_wdata, a_rdata;
  logic       b_valid, b_ready, b_we, b_rvalid;
  logic [3:0] b_addr, b_wdata, b_rdata;
  logic       ram_we, ram_re, busy;
  logic [3:0] ram_addr, ram_din, ram_dout;

  // Instance 2: RD_LAT = 3, B port idle
  logic       c_a_valid, c_a_ready, c_a_we, c_a_rvalid;
  logic [3:0] c_a_addr, c_a_wdata, c_a_rdata;
  logic       c_b_valid, c_b_ready, c_b_we, c_b_rvalid;
  logic [3:0] c_b_addr, c_b_wdata, c_b_rdata;
  logic       c_ram_we, c_ram_re, c_busy;
  logic [3:0] c_ram_addr, c_ram_din, c_ram_dout;

  sync_ram_arbiter #(.ADDR_W(4), .DATA_W(4), .RD_LAT(1)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_valid(b_valid), .b_ready(b_ready), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .ram_we(ram_we), .ram_re(ram_re), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout), .busy(busy)
  );

  sync_ram_arbiter #(.ADDR_W(4), .DATA_W(4), .RD_LAT(3)) dut3 (
    .clk(clk), .rst(rst),
    .a_valid(c_a_valid), .a_ready(c_a_ready), .a_we(c_a_we), .a_addr(c_a_addr),
    .a_wdata(c_a_wdata), .a_rvalid(c_a_rvalid), .a_rdata(c_a_rdata),
    .b_valid(c_b_valid), .b_ready(c_b_ready), .b_we(c_b_we), .b_addr(c_b_addr),
    .b_wdata(c_b_wdata), .b_rvalid(c_b_rvalid), .b_rdata(c_b_rdata),
    .ram_we(c_ram_we), .ram_re(c_ram_re), .ram_addr(c_ram_addr), .ram_din(c_ram_din),
    .ram_dout(c_ram_dout), .busy(c_busy)
  );

  // Behavioural SyncRAMs: dout is valid RD_LAT cycles after the issue-cycle clock edge
  logic [3:0] mem1 [16];
  logic [3:0] pipe1 [4];
  logic [3:0] mem3 [16];
  logic [3:0] pipe3 [4];

  always @(posedge clk) begin
    if (ram_we) mem1[ram_addr] <= ram_din;
    pipe1[0] <= mem1[ram_addr];
    for (int i = 1; i < 4; i++) pipe1[i] <= pipe1[i-1];
    if (c_ram_we) mem3[c_ram_addr] <= c_ram_din;
    pipe3[0] <= mem3[c_ram_addr];
    for (int i = 1; i < 4; i++) pipe3[i] <= pipe3[i-1];
  end

  assign ram_dout   = pipe1[0];
  assign c_ram_dout = pipe3[2];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int ia;
    int ib;
    logic exp_a;
    rst = 1'b1;
    a_valid = 1'b1; a_we = 1'b1; a_addr = 4'h0; a_wdata = 4'h1;
    b_valid = 1'b1; b_we = 1'b1; b_addr = 4'h0; b_wdata = 4'h3;
    c_a_valid = 1'b0; c_a_we = 1'b0; c_a_addr = 4'h0; c_a_wdata = 4'h0;
    c_b_valid = 1'b0; c_b_we = 1'b0; c_b_addr = 4'h0; c_b_wdata = 4'h0;

    // Reset held 3 cycles with both requesters valid
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_a_ready", 32'(a_ready), 0);
      chk("rst_b_ready", 32'(b_ready), 0);
      chk("rst_ram_we", 32'(ram_we), 0);
      chk("rst_ram_re", 32'(ram_re), 0);
      chk("rst_ram_addr", 32'(ram_addr), 0);
      chk("rst_ram_din", 32'(ram_din), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_a_rvalid", 32'(a_rvalid), 0);
      chk("rst_b_rdata", 32'(b_rdata), 0);
    end
    rst = 1'b0;
    #1;
    chk("first_tie_a_ready", 32'(a_ready), 1);
    chk("first_tie_b_ready", 32'(b_ready), 0);
    b_valid = 1'b0;
    tick();
    chk("first_wr_we", 32'(ram_we), 1);
    chk("first_wr_din", 32'(ram_din), 1);
    chk("issue_a_ready", 32'(a_ready), 0);
    a_valid = 1'b0;
    tick();
    chk("first_wr_idle", 32'(busy), 0);

    // A writes addr 2 <- 4, then reads it back
    a_valid = 1'b1; a_we = 1'b1; a_addr = 4'h2; a_wdata = 4'h4;
    #1;
    chk("t2_wr_ready", 32'(a_ready), 1);
    tick();
    a_valid = 1'b0;
    chk("t2_wr_we", 32'(ram_we), 1);
    chk("t2_wr_re", 32'(ram_re), 0);
    chk("t2_wr_addr", 32'(ram_addr), 2);
    chk("t2_wr_din", 32'(ram_din), 4);
    tick();
    chk("t2_wr_we_pulse", 32'(ram_we), 0);
    chk("t2_wr_busy", 32'(busy), 0);
    a_valid = 1'b1; a_we = 1'b0; a_addr = 4'h2;
    #1;
    chk("t2_rd_ready", 32'(a_ready), 1);
    tick();
    a_valid = 1'b0;
    chk("t2_rd_re", 32'(ram_re), 1);
    chk("t2_rd_we", 32'(ram_we), 0);
    chk("t2_rd_addr", 32'(ram_addr), 2);
    tick();
    chk("t2_rdwait_rvalid", 32'(a_rvalid), 0);
    chk("t2_rdwait_re", 32'(ram_re), 0);
    chk("t2_rdwait_ready", 32'(a_ready), 0);
    tick();
    chk("t2_resp_a_rvalid", 32'(a_rvalid), 1);
    chk("t2_resp_a_rdata", 32'(a_rdata), 4);
    chk("t2_resp_b_rvalid", 32'(b_rvalid), 0);
    tick();
    chk("t2_after_rvalid", 32'(a_rvalid), 0);
    chk("t2_after_busy", 32'(busy), 0);
    chk("t2_rdata_hold", 32'(a_rdata), 4);

    // B alone writes addr 0 <- 3; B becomes last grant
    b_valid = 1'b1; b_we = 1'b1; b_addr = 4'h0; b_wdata = 4'h3;
    #1;
    chk("bonly_b_ready", 32'(b_ready), 1);
    chk("bonly_a_ready", 32'(a_ready), 0);
    tick();
    b_valid = 1'b0;
    chk("bonly_din", 32'(ram_din), 3);
    tick();

    // Contention: A writes 5..8 <- 1..4, B writes 5..8 <- 9..C, grants alternate A,B,...
    ia = 0; ib = 0;
    a_valid = 1'b1; a_we = 1'b1; a_addr = 4'h5; a_wdata = 4'h1;
    b_valid = 1'b1; b_we = 1'b1; b_addr = 4'h5; b_wdata = 4'h9;
    for (int k = 0; k < 8; k++) begin
      exp_a = ((k % 2) == 0);
      #1;
      chk("rr_a_ready", 32'(a_ready), 32'(exp_a));
      chk("rr_b_ready", 32'(b_ready), 32'(!exp_a));
      tick();
      chk("rr_we", 32'(ram_we), 1);
      chk("rr_addr", 32'(ram_addr), 32'(5 + (exp_a ? ia : ib)));
      chk("rr_din", 32'(ram_din), 32'(exp_a ? (1 + ia) : (9 + ib)));
      if (exp_a) begin
        ia++;
        if (ia == 4) a_valid = 1'b0;
        else begin a_addr = 4'(5 + ia); a_wdata = 4'(1 + ia); end
      end else begin
        ib++;
        if (ib == 4) b_valid = 1'b0;
        else begin b_addr = 4'(5 + ib); b_wdata = 4'(9 + ib); end
      end
      tick();
      chk("rr_we_gap", 32'(ram_we), 0);
    end

    // B writes addr 5 <- 7 while A waits to read addr 5
    b_valid = 1'b1; b_we = 1'b1; b_addr = 4'h5; b_wdata = 4'h7;
    #1;
    chk("t4_b_ready", 32'(b_ready), 1);
    tick();
    b_valid = 1'b0;
    a_valid = 1'b1; a_we = 1'b0; a_addr = 4'h5;
    #1;
    chk("t4_a_wait", 32'(a_ready), 0);
    chk("t4_b_din", 32'(ram_din), 7);
    tick();
    chk("t4_a_ready", 32'(a_ready), 1);
    tick();
    a_valid = 1'b0;
    chk("t4_re", 32'(ram_re), 1);
    chk("t4_addr", 32'(ram_addr), 5);
    tick();
    tick();
    chk("t4_a_rvalid", 32'(a_rvalid), 1);
    chk("t4_a_rdata", 32'(a_rdata), 7);
    chk("t4_b_rvalid", 32'(b_rvalid), 0);
    tick();
    chk("t4_after_rvalid", 32'(a_rvalid), 0);

    // Reset during the RDWAIT of an A read of addr 9
    a_valid = 1'b1; a_we = 1'b0; a_addr = 4'h9;
    tick();
    a_valid = 1'b0;
    chk("t5_re", 32'(ram_re), 1);
    tick();
    chk("t5_rdwait_busy", 32'(busy), 1);
    rst = 1'b1;
    tick();
    chk("t5_busy", 32'(busy), 0);
    chk("t5_re_low", 32'(ram_re), 0);
    chk("t5_rvalid", 32'(a_rvalid), 0);
    chk("t5_rdata", 32'(a_rdata), 0);
    rst = 1'b0;
    tick();
    chk("t5_no_rvalid", 32'(a_rvalid), 0);

    // Latency-3 instance: write F <- A, read it back
    c_a_valid = 1'b1; c_a_we = 1'b1; c_a_addr = 4'hF; c_a_wdata = 4'hA;
    #1;
    chk("t6_wr_ready", 32'(c_a_ready), 1);
    tick();
    c_a_valid = 1'b0;
    chk("t6_wr_we", 32'(c_ram_we), 1);
    chk("t6_wr_addr", 32'(c_ram_addr), 32'hF);
    chk("t6_wr_din", 32'(c_ram_din), 32'hA);
    tick();
    c_a_valid = 1'b1; c_a_we = 1'b0; c_a_addr = 4'hF;
    #1;
    chk("t6_idle_busy", 32'(c_busy), 0);
    chk("t6_rd_ready", 32'(c_a_ready), 1);
    tick();
    c_a_valid = 1'b0;
    chk("t6_issue_busy", 32'(c_busy), 1);
    chk("t6_issue_re", 32'(c_ram_re), 1);
    for (int i = 2; i <= 4; i++) begin
      tick();
      chk("t6_wait_busy", 32'(c_busy), 1);
      chk("t6_wait_rvalid", 32'(c_a_rvalid), 0);
    end
    tick();
    chk("t6_resp_rvalid", 32'(c_a_rvalid), 1);
    chk("t6_resp_rdata", 32'(c_a_rdata), 32'hA);
    chk("t6_resp_busy", 32'(c_busy), 1);
    tick();
    chk("t6_after_rvalid", 32'(c_a_rvalid), 0);
    chk("t6_after_busy", 32'(c_busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
